// File: rtl/bfp_stream_converter.sv
// rtl/bfp_stream_converter.sv - streaming FP-to-BFP group converter with valid/ready on both sides
// Optional macro BFP_RNE_EN selects round-to-nearest-even instead of round-half-up.
module bfp_stream_converter #(
    parameter int GRPSIZE    = 16,
    parameter int LANES      = 4,
    parameter int FPEXPSIZE  = 8,
    parameter int FPMANSIZE  = 23,
    parameter int BFPEXPSIZE = 8,
    parameter int BFPMANSIZE = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [FPEXPSIZE-1:0]  i_exps [0:LANES-1],
    input  logic [FPMANSIZE:0]    i_mans [0:LANES-1],
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [BFPEXPSIZE-1:0] o_bfp_exp,
    output logic [BFPMANSIZE:0]   o_bfps [0:GRPSIZE-1],
    output logic                  o_sat
);

    localparam int          BEATS = GRPSIZE / LANES;
    localparam int          CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned EMAX  = (1 << BFPEXPSIZE) - 1;
`ifdef BFP_RNE_EN
    localparam bit          RNE   = 1'b1;
`else
    localparam bit          RNE   = 1'b0;
`endif

    typedef enum logic [1:0] {S_COLLECT, S_ALIGN, S_OUTPUT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [BFPEXPSIZE-1:0] r_max;
    logic [BFPEXPSIZE-1:0] r_eexp [0:GRPSIZE-1];
    logic [FPMANSIZE:0]    r_man  [0:GRPSIZE-1];
    logic [BFPEXPSIZE-1:0] w_beat_exp [0:LANES-1];
    logic [BFPEXPSIZE-1:0] w_beat_max;
    logic [BFPMANSIZE+1:0] w_res [0:GRPSIZE-1];
    logic                  w_any_sat;
    logic                  w_take;
    logic                  w_last;

    // Zero stays zero so denormals never raise the shared exponent above real values.
    function automatic logic [BFPEXPSIZE-1:0] eff_exp(input logic [FPEXPSIZE-1:0] e);
        int unsigned t;
        t = 32'(e) + 32'd1;
        if (e == '0)
            return '0;
        else if (t > EMAX)
            return BFPEXPSIZE'(EMAX);
        else
            return BFPEXPSIZE'(t);
    endfunction

    // Returns {sat, sign, magnitude}.
    function automatic logic [BFPMANSIZE+1:0] align_round(
        input logic [BFPEXPSIZE-1:0] ee,
        input logic [BFPEXPSIZE-1:0] mx,
        input logic [FPMANSIZE:0]    m
    );
        logic [BFPEXPSIZE-1:0] s;
        logic [FPMANSIZE-1:0]  base;
        logic [FPMANSIZE-1:0]  a;
        logic [BFPMANSIZE-1:0] q;
        logic                  g;
        logic                  sticky;
        logic                  inc;
        s      = mx - ee;
        base   = (ee != '0) ? {1'b1, m[FPMANSIZE-1:1]} : m[FPMANSIZE-1:0];
        a      = base >> s;
        q      = a[FPMANSIZE-1 -: BFPMANSIZE];
        g      = a[FPMANSIZE-1-BFPMANSIZE];
        sticky = |a[FPMANSIZE-2-BFPMANSIZE:0];
        inc    = g && (!RNE || sticky || q[0]);
        if (inc && (&q))
            return {1'b1, m[FPMANSIZE], q};
        else
            return {1'b0, m[FPMANSIZE], q + BFPMANSIZE'(inc)};
    endfunction

    assign w_take = i_valid && o_ready;
    assign w_last = (r_cnt == CW'(BEATS - 1));

    always_comb begin
        w_beat_max = r_max;
        for (int l = 0; l < LANES; l++) begin
            w_beat_exp[l] = eff_exp(i_exps[l]);
            if (w_beat_exp[l] > w_beat_max)
                w_beat_max = w_beat_exp[l];
        end
    end

    always_comb begin
        w_any_sat = 1'b0;
        for (int i = 0; i < GRPSIZE; i++) begin
            w_res[i]  = align_round(r_eexp[i], r_max, r_man[i]);
            w_any_sat = w_any_sat | w_res[i][BFPMANSIZE+1];
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_COLLECT: begin
                o_ready = 1'b1;
                if (i_valid && w_last)
                    w_next = S_ALIGN;
            end
            S_ALIGN: w_next = S_OUTPUT;
            S_OUTPUT: begin
                o_valid = 1'b1;
                if (i_ready)
                    w_next = S_COLLECT;
            end
            default: w_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_max   <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                r_max <= w_beat_max;
            end else if (r_state == S_OUTPUT && i_ready) begin
                r_max <= '0;
            end
        end
    end

    // Element storage needs no reset: every slot is rewritten before ALIGN reads it.
    always_ff @(posedge i_clk) begin
        if (w_take) begin
            for (int l = 0; l < LANES; l++) begin
                r_eexp[int'(r_cnt) * LANES + l] <= w_beat_exp[l];
                r_man[int'(r_cnt) * LANES + l]  <= i_mans[l];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bfp_exp <= '0;
            o_sat     <= 1'b0;
            for (int i = 0; i < GRPSIZE; i++)
                o_bfps[i] <= '0;
        end else if (r_state == S_ALIGN) begin
            o_bfp_exp <= r_max;
            o_sat     <= w_any_sat;
            for (int i = 0; i < GRPSIZE; i++)
                o_bfps[i] <= w_res[i][BFPMANSIZE:0];
        end
    end

endmodule

// File: tb/tb_bfp_stream_converter.sv
// tb/tb_bfp_stream_converter.sv - directed self-checking bench for bfp_stream_converter
module tb_bfp_stream_converter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_exps [0:3];
    logic [23:0] i_mans [0:3];
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_bfp_exp;
    logic [3:0]  o_bfps [0:15];
    logic        o_sat;

    logic [7:0]  t_exp [16];
    logic [23:0] t_man [16];
    int          n_vec = 0;
    int          n_err = 0;

    bfp_stream_converter dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_exps    (i_exps),
        .i_mans    (i_mans),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_bfp_exp (o_bfp_exp),
        .o_bfps    (o_bfps),
        .o_sat     (o_sat)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_group();
        for (int i = 0; i < 16; i++) begin
            t_exp[i] = 8'd0;
            t_man[i] = 24'd0;
        end
    endtask

    task automatic drive_beat(input int b);
        for (int l = 0; l < 4; l++) begin
            i_exps[l] = t_exp[b * 4 + l];
            i_mans[l] = t_man[b * 4 + l];
        end
        i_valid = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic send_group();
        for (int b = 0; b < 4; b++)
            drive_beat(b);
        i_valid = 1'b0;
        check("valid_in_align", {31'd0, o_valid}, 32'd0);
        check("ready_in_align", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        check("valid_after_align", {31'd0, o_valid}, 32'd1);
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check("valid_after_hs", {31'd0, o_valid}, 32'd0);
        check("ready_after_hs", {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        for (int l = 0; l < 4; l++) begin
            i_exps[l] = 8'd0;
            i_mans[l] = 24'd0;
        end
        #22;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_exp", {24'd0, o_bfp_exp}, 32'd0);
        check("rst_sat", {31'd0, o_sat}, 32'd0);
        check("rst_bfps0", {28'd0, o_bfps[0]}, 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Basic group: 1.0 everywhere.
        clear_group();
        for (int i = 0; i < 16; i++) t_exp[i] = 8'd127;
        send_group();
        check("basic_exp", {24'd0, o_bfp_exp}, 32'd128);
        check("basic_sat", {31'd0, o_sat}, 32'd0);
        for (int i = 0; i < 16; i++)
            check($sformatf("basic_bfps%0d", i), {28'd0, o_bfps[i]}, 32'h4);
        handshake();

        // Mixed exponents, negative elements, signed zero.
        clear_group();
        t_exp[0] = 8'd127;
        t_exp[5] = 8'd126; t_man[5] = 24'h800000;
        t_exp[6] = 8'd125; t_man[6] = 24'h800000;
        t_man[7] = 24'h800000;
        send_group();
        check("mix_exp", {24'd0, o_bfp_exp}, 32'd128);
        check("mix_bfps0", {28'd0, o_bfps[0]}, 32'h4);
        check("mix_bfps5", {28'd0, o_bfps[5]}, 32'hA);
        check("mix_bfps6", {28'd0, o_bfps[6]}, 32'h9);
        check("mix_bfps7", {28'd0, o_bfps[7]}, 32'h8);
        check("mix_bfps1", {28'd0, o_bfps[1]}, 32'h0);
        check("mix_bfps15", {28'd0, o_bfps[15]}, 32'h0);
        handshake();

        // Rounding: exact tie, above-tie, and tie with odd q.
        clear_group();
        t_exp[0] = 8'd127; t_man[0] = 24'h100000;
        t_exp[1] = 8'd127; t_man[1] = 24'h180000;
        t_exp[2] = 8'd127; t_man[2] = 24'h300000;
        send_group();
`ifdef BFP_RNE_EN
        check("tie_bfps0", {28'd0, o_bfps[0]}, 32'h4);
`else
        check("tie_bfps0", {28'd0, o_bfps[0]}, 32'h5);
`endif
        check("above_tie_bfps1", {28'd0, o_bfps[1]}, 32'h5);
        check("odd_tie_bfps2", {28'd0, o_bfps[2]}, 32'h6);
        check("tie_sat", {31'd0, o_sat}, 32'd0);
        handshake();

        // Exponent saturation at 255.
        clear_group();
        t_exp[0] = 8'd255;
        send_group();
        check("expsat_exp", {24'd0, o_bfp_exp}, 32'd255);
        check("expsat_bfps0", {28'd0, o_bfps[0]}, 32'h4);
        handshake();

        // Mantissa saturation, then held under backpressure with ignored beats.
        clear_group();
        t_exp[0] = 8'd127; t_man[0] = 24'h7FFFFF;
        send_group();
        check("sat_bfps0", {28'd0, o_bfps[0]}, 32'h7);
        check("sat_flag", {31'd0, o_sat}, 32'd1);
        for (int l = 0; l < 4; l++) begin
            i_exps[l] = 8'd200;
            i_mans[l] = 24'h7FFFFF;
        end
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_ready", {31'd0, o_ready}, 32'd0);
            check("bp_exp", {24'd0, o_bfp_exp}, 32'd128);
            check("bp_bfps0", {28'd0, o_bfps[0]}, 32'h7);
            check("bp_sat", {31'd0, o_sat}, 32'd1);
        end
        i_valid = 1'b0;
        handshake();

        // Group after backpressure must be unaffected by the ignored beats.
        clear_group();
        for (int i = 0; i < 16; i++) t_exp[i] = 8'd127;
        send_group();
        check("post_bp_exp", {24'd0, o_bfp_exp}, 32'd128);
        check("post_bp_bfps5", {28'd0, o_bfps[5]}, 32'h4);
        check("post_bp_sat", {31'd0, o_sat}, 32'd0);
        handshake();

        // Reset mid-group discards the partial exp=200 beats.
        clear_group();
        for (int i = 0; i < 16; i++) t_exp[i] = 8'd200;
        drive_beat(0);
        drive_beat(1);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        check("midrst_ready", {31'd0, o_ready}, 32'd1);
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        for (int i = 0; i < 16; i++) t_exp[i] = 8'd127;
        send_group();
        check("midrst_exp", {24'd0, o_bfp_exp}, 32'd128);
        check("midrst_bfps15", {28'd0, o_bfps[15]}, 32'h4);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
